// File: rtl/im_sync_if.sv
// Fetch-side request/response bundle for im_sync.
// The master is the fetch stage and the slave is the instruction memory.
interface im_sync_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/im_sync.sv
// Synchronous-read instruction memory with a single registered response stage.
// Fetches are rebased against BASE_ADDR, and misaligned or out-of-range fetches return NOP_WORD with an error code.
module im_sync #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h0000_3000,
  parameter string              INIT_FILE = "code.txt",
  parameter logic [DATA_W-1:0]  NOP_WORD  = 32'h0000_0000,
  parameter int                 CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  im_sync_if.slave          bus,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // NOTE: the array is never reset; memories hold no reset value.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q,  rsp_addr_d;
  logic [1:0]        rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic [ADDR_W-1:0] word_off;
  logic [IDX_W-1:0]  idx;

  // Range is tested on the raw address first so a fetch below the base cannot wrap into range.
  assign word_off     = (bus.req_addr - BASE_ADDR) >> 2;
  assign idx          = word_off[IDX_W-1:0];
  assign misaligned   = |bus.req_addr[1:0];
  assign out_of_range = (bus.req_addr < BASE_ADDR) || (word_off >= DEPTH_A);

  assign bus.req_ready = !bus.flush && (!rsp_valid_q || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  // NOTE: combinational next-state uses blocking assignments with defaults first, so no latch is inferred.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_err_d   = rsp_err_q;
    fetch_cnt_d = fetch_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (bus.flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = bus.req_addr;
      rsp_err_d   = {out_of_range, misaligned};
      rsp_data_d  = (out_of_range || misaligned) ? NOP_WORD : mem[idx];
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (accept) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      if (out_of_range || misaligned) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_err_q   <= '0;
      fetch_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_err_q   <= rsp_err_d;
      fetch_cnt_q <= fetch_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_err   = rsp_err_q;
  assign fetch_cnt     = fetch_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule
